// File: rtl/door_lock_param.sv
// Keypad door-lock controller: buffers keypad digits, checks them against a programmable
// code, and drives a timed unlock window and a timed lockout after repeated wrong attempts.
module door_lock_param #(
    parameter int DIGIT_W    = 4,
    parameter int CODE_LEN   = 4,
    parameter int MAX_TRIES  = 3,
    parameter int UNLOCK_CYC = 50,
    parameter int LOCK_CYC   = 200,
    parameter logic [DIGIT_W*CODE_LEN-1:0] DEFAULT_CODE = 16'h1234
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           digit_valid,
    input  logic [DIGIT_W-1:0]             digit,
    input  logic                           enter,
    input  logic                           clear,
    input  logic                           set_code,
    output logic                           unlock,
    output logic                           alarm,
    output logic                           lock_out,
    output logic [$clog2(MAX_TRIES+1)-1:0] fail_cnt,
    output logic [$clog2(CODE_LEN+1)-1:0]  entry_cnt
);
    localparam int CODE_W = DIGIT_W * CODE_LEN;
    localparam int FW     = $clog2(MAX_TRIES + 1);
    localparam int EW     = $clog2(CODE_LEN + 1);
    localparam int TMAX   = (UNLOCK_CYC > LOCK_CYC) ? UNLOCK_CYC : LOCK_CYC;
    localparam int TW     = $clog2(TMAX + 1);

    localparam logic [EW-1:0] FULL_CNT = EW'(CODE_LEN);
    localparam logic [FW-1:0] LAST_TRY = FW'(MAX_TRIES - 1);
    localparam logic [FW-1:0] MAX_FAIL = FW'(MAX_TRIES);
    localparam logic [TW-1:0] UNLOCK_T = TW'(UNLOCK_CYC);
    localparam logic [TW-1:0] LOCK_T   = TW'(LOCK_CYC);

    typedef enum logic [1:0] {S_ENTRY, S_OPEN, S_PROGRAM, S_LOCKED} state_t;

    state_t              state, state_nx;
    logic [CODE_W-1:0]   code_reg, code_nx;
    logic [CODE_W-1:0]   buffer, buf_nx;
    logic [EW-1:0]       cnt_nx;
    logic                overflow, ovf_nx;
    logic [FW-1:0]       fail_nx;
    logic [TW-1:0]       timer, timer_nx;
    logic                unlock_nx, alarm_nx, lock_nx;

    logic [CODE_W-1:0]   shifted;
    logic                entry_full, entry_ok;

    assign shifted    = (buffer << DIGIT_W) | CODE_W'(digit);
    assign entry_full = (entry_cnt == FULL_CNT);
    assign entry_ok   = entry_full && !overflow;

    always_comb begin
        state_nx  = state;
        code_nx   = code_reg;
        buf_nx    = buffer;
        cnt_nx    = entry_cnt;
        ovf_nx    = overflow;
        fail_nx   = fail_cnt;
        timer_nx  = timer;
        unlock_nx = unlock;
        alarm_nx  = 1'b0;
        lock_nx   = lock_out;
        case (state)
            S_ENTRY, S_PROGRAM: begin
                // enter/clear outrank a coincident digit, which is dropped
                if (enter || clear) begin
                    buf_nx = '0;
                    cnt_nx = '0;
                    ovf_nx = 1'b0;
                end else if (digit_valid) begin
                    if (entry_full) begin
                        ovf_nx = 1'b1;
                    end else begin
                        buf_nx = shifted;
                        cnt_nx = entry_cnt + EW'(1);
                    end
                end
                if (state == S_PROGRAM) begin
                    if (enter || clear) begin
                        state_nx  = S_ENTRY;
                        unlock_nx = 1'b0;
                        timer_nx  = '0;
                    end
                    if (enter && entry_ok)
                        code_nx = buffer;
                end else if (enter) begin
                    if (entry_ok && buffer == code_reg) begin
                        state_nx  = S_OPEN;
                        unlock_nx = 1'b1;
                        fail_nx   = '0;
                        timer_nx  = UNLOCK_T;
                    end else if (fail_cnt == LAST_TRY) begin
                        state_nx  = S_LOCKED;
                        fail_nx   = MAX_FAIL;
                        lock_nx   = 1'b1;
                        alarm_nx  = 1'b1;
                        timer_nx  = LOCK_T;
                    end else begin
                        fail_nx   = fail_cnt + FW'(1);
                        alarm_nx  = 1'b1;
                    end
                end
            end
            S_OPEN: begin
                if (set_code) begin
                    state_nx = S_PROGRAM;
                    buf_nx   = '0;
                    cnt_nx   = '0;
                    ovf_nx   = 1'b0;
                end else if (timer <= TW'(1)) begin
                    state_nx  = S_ENTRY;
                    unlock_nx = 1'b0;
                    timer_nx  = '0;
                end else begin
                    timer_nx = timer - TW'(1);
                end
            end
            S_LOCKED: begin
                alarm_nx = 1'b1;
                if (timer <= TW'(1)) begin
                    state_nx = S_ENTRY;
                    lock_nx  = 1'b0;
                    alarm_nx = 1'b0;
                    fail_nx  = '0;
                    buf_nx   = '0;
                    cnt_nx   = '0;
                    ovf_nx   = 1'b0;
                    timer_nx = '0;
                end else begin
                    timer_nx = timer - TW'(1);
                end
            end
            default: state_nx = S_ENTRY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_ENTRY;
            code_reg  <= DEFAULT_CODE;
            buffer    <= '0;
            entry_cnt <= '0;
            overflow  <= 1'b0;
            fail_cnt  <= '0;
            timer     <= '0;
            unlock    <= 1'b0;
            alarm     <= 1'b0;
            lock_out  <= 1'b0;
        end else begin
            state     <= state_nx;
            code_reg  <= code_nx;
            buffer    <= buf_nx;
            entry_cnt <= cnt_nx;
            overflow  <= ovf_nx;
            fail_cnt  <= fail_nx;
            timer     <= timer_nx;
            unlock    <= unlock_nx;
            alarm     <= alarm_nx;
            lock_out  <= lock_nx;
        end
    end

endmodule

// File: tb/tb_door_lock_param.sv
// Bench for door_lock_param: directed scenarios followed by random strobes, every cycle
// checked against a digit-queue / countdown reference model.
module tb_door_lock_param;
    localparam int DW = 4;
    localparam int CL = 4;
    localparam int MT = 3;
    localparam int UC = 50;
    localparam int LC = 200;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          digit_valid = 1'b0;
    logic [DW-1:0] digit = '0;
    logic          enter = 1'b0;
    logic          clear = 1'b0;
    logic          set_code = 1'b0;
    logic          unlock, alarm, lock_out;
    logic [1:0]    fail_cnt;
    logic [2:0]    entry_cnt;

    always #5 clk = ~clk;

    door_lock_param #(
        .DIGIT_W(DW), .CODE_LEN(CL), .MAX_TRIES(MT),
        .UNLOCK_CYC(UC), .LOCK_CYC(LC), .DEFAULT_CODE(16'h1234)
    ) dut (
        .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit(digit),
        .enter(enter), .clear(clear), .set_code(set_code),
        .unlock(unlock), .alarm(alarm), .lock_out(lock_out),
        .fail_cnt(fail_cnt), .entry_cnt(entry_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: entered digits, stored code, remaining open / lockout cycles
    int m_ent[$];
    int m_code[$];
    bit m_ovf;
    int m_fail;
    int m_open;
    int m_lock;
    bit m_prog;
    bit m_pulse;

    function automatic void m_reset();
        m_ent.delete();
        m_code = {1, 2, 3, 4};
        m_ovf = 0; m_fail = 0; m_open = 0; m_lock = 0; m_prog = 0; m_pulse = 0;
    endfunction

    function automatic void m_clear_entry();
        m_ent.delete();
        m_ovf = 0;
    endfunction

    function automatic void m_add(input int d);
        if (m_ent.size() == CL) m_ovf = 1;
        else m_ent.push_back(d);
    endfunction

    function automatic void m_step(input bit dv, input int d, input bit en, input bit cl, input bit sc);
        bit ok;
        m_pulse = 0;
        if (m_lock > 0) begin
            m_lock--;
            if (m_lock == 0) begin
                m_fail = 0;
                m_clear_entry();
            end
        end else if (m_prog) begin
            if (en) begin
                if (m_ent.size() == CL && !m_ovf) m_code = m_ent;
                m_prog = 0; m_open = 0; m_clear_entry();
            end else if (cl) begin
                m_prog = 0; m_open = 0; m_clear_entry();
            end else if (dv) m_add(d);
        end else if (m_open > 0) begin
            if (sc) begin
                m_prog = 1;
                m_clear_entry();
            end else m_open--;
        end else begin
            if (en) begin
                ok = (m_ent.size() == CL) && !m_ovf;
                if (ok) foreach (m_ent[i]) if (m_ent[i] != m_code[i]) ok = 0;
                if (ok) begin
                    m_open = UC; m_fail = 0;
                end else if (m_fail + 1 == MT) begin
                    m_lock = LC; m_fail = MT;
                end else begin
                    m_fail++; m_pulse = 1;
                end
                m_clear_entry();
            end else if (cl) m_clear_entry();
            else if (dv) m_add(d);
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("unlock",    32'(unlock),    32'(m_open > 0 || m_prog));
        chk("alarm",     32'(alarm),     32'(m_lock > 0 || m_pulse));
        chk("lock_out",  32'(lock_out),  32'(m_lock > 0));
        chk("fail_cnt",  32'(fail_cnt),  32'(m_fail));
        chk("entry_cnt", 32'(entry_cnt), 32'(m_ent.size()));
    endtask

    task automatic cyc(input bit dv, input int d, input bit en, input bit cl, input bit sc);
        @(negedge clk);
        digit_valid = dv; digit = DW'(d); enter = en; clear = cl; set_code = sc;
        @(posedge clk);
        m_step(dv, d, en, cl, sc);
        #1 check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic keys(input int n, input logic [31:0] val);
        logic [31:0] v;
        v = val;
        for (int i = 0; i < n; i++) cyc(1, int'((v >> (4 * (n - 1 - i))) & 32'hF), 0, 0, 0);
    endtask

    task automatic press_enter();
        cyc(0, 0, 1, 0, 0);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        m_reset();
        #1 check_all();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int c[$];
        m_reset();
        #1 check_all();
        @(negedge clk);
        rst = 1'b1;
        idle(2);

        // default code opens for exactly UC cycles
        keys(4, 32'h1234); press_enter(); idle(UC + 3);

        // one wrong attempt then the right one
        keys(4, 32'h1244); press_enter(); idle(2);
        keys(4, 32'h1234); press_enter(); idle(UC + 3);

        // lockout: correct code ignored, automatic recovery
        for (int i = 0; i < MT; i++) begin keys(4, 32'h1111); press_enter(); end
        keys(4, 32'h1234); press_enter();
        idle(LC);
        keys(4, 32'h1234); press_enter(); idle(UC + 3);

        // short entry, overflow, clear
        keys(3, 32'h123); press_enter();
        keys(5, 32'h12345); press_enter();
        keys(1, 32'h9); cyc(0, 0, 0, 1, 0);
        keys(4, 32'h1234); press_enter(); idle(UC + 3);

        // reprogramming, including a rejected 3-digit code
        keys(4, 32'h1234); press_enter(); idle(3);
        cyc(0, 0, 0, 0, 1); keys(4, 32'h5678); press_enter(); idle(2);
        keys(4, 32'h1234); press_enter();
        keys(4, 32'h5678); press_enter(); idle(3);
        cyc(0, 0, 0, 0, 1); keys(3, 32'h567); press_enter(); idle(2);
        keys(4, 32'h5678); press_enter(); idle(UC + 3);

        // reset in the middle of a lockout
        for (int i = 0; i < MT; i++) begin keys(4, 32'h2222); press_enter(); end
        idle(100);
        async_reset();
        idle(2);

        // a programmed code does not survive reset
        keys(4, 32'h1234); press_enter(); idle(2);
        cyc(0, 0, 0, 0, 1); keys(4, 32'h5678); press_enter(); idle(2);
        async_reset();
        keys(4, 32'h1234); press_enter(); idle(UC + 3);

        // coincident strobes: digit dropped under enter and under clear
        keys(3, 32'h123); cyc(1, 4, 1, 0, 0);
        keys(2, 32'h12); cyc(1, 3, 0, 1, 0);
        keys(4, 32'h1234); press_enter(); idle(UC + 3);

        // random strobes, occasionally typing the currently stored code
        for (int it = 0; it < 2500; it++) begin
            if ($urandom_range(0, 99) < 4) begin
                c = m_code;
                foreach (c[i]) cyc(1, c[i], 0, 0, 0);
                press_enter();
            end else begin
                cyc($urandom_range(0, 99) < 45, int'($urandom_range(0, 15)),
                    $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 3,
                    $urandom_range(0, 99) < 8);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
